loss_accum: RTL and testbench
=============================

LOSS_ACCUM -- requirements
Module: loss_accum

Interface
REQ-001 Parameter LANES, default 4: parallel elements per beat.
REQ-002 Parameter DATA_W, default 32: signed width of each data/target element.
REQ-003 Parameter LOSS_W, default 32: unsigned width of each per-lane loss.
REQ-004 Parameter ACC_W, default 48: unsigned width of the running vector sum.
REQ-005 Parameter MAX_BEATS, default 64: beats per vector before a forced terminate.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 valid_in  input  1  input beat valid.
REQ-009 ready_out  output  1  block accepts a beat this cycle.
REQ-010 data_in  input  LANES x DATA_W signed  prediction elements.
REQ-011 target_in  input  LANES x DATA_W signed  target elements.
REQ-012 last_in  input  1  beat is the final beat of the vector.
REQ-013 mode_in  input  loss_mode_t  L1 (absolute difference) or L2 (squared difference).
REQ-014 valid_out  output  1  output beat valid.
REQ-015 ready_in  input  1  downstream accepts the output beat.
REQ-016 loss_out  output  LANES x LOSS_W unsigned  per-lane loss of the beat.
REQ-017 sum_out  output  ACC_W unsigned  running vector sum including this beat.
REQ-018 last_out  output  1  beat closes the vector; sum_out is the final vector loss.
REQ-019 sat_out  output  1  some lane or sum clipped within the current vector (sticky to last_out).
REQ-020 len_err_out  output  1  vector forcibly terminated at MAX_BEATS, valid with last_out.

Function
REQ-021 Input accepted when valid_in && ready_out; ready_out = !valid_out || ready_in (pipeline enable), combinational.
REQ-022 Two-stage pipeline: stage 1 registers per-lane loss, lane sum and flags; stage 2 registers the output beat; latency 2 enabled cycles.
REQ-023 When the enable is low, both stages hold and no state changes.
REQ-024 Per lane, diff = data - target computed at DATA_W+1 bits with no overflow.
REQ-025 L1: loss = |diff|; L2: loss = diff*diff; result saturates to 2^LOSS_W-1 and flags sat.
REQ-026 Lane sum = unsigned sum of LANES losses at LOSS_W+clog2(LANES) bits, no overflow.
REQ-027 Accumulator adds the lane sum in stage 2, saturating to 2^ACC_W-1 and flagging sat.
REQ-028 FSM states IDLE and ACCUM; IDLE->ACCUM on an accepted non-last beat; ACCUM->IDLE on an accepted last or forced-last beat.
REQ-029 Accepted beat in IDLE latches mode_in for the whole vector; mode_in ignored in ACCUM.
REQ-030 Single-beat vector (last_in in IDLE) stays in IDLE and emits last_out on that beat.
REQ-031 Beat counter increments per accepted beat; the MAX_BEATS-th beat without last_in is treated as last and sets len_err_out.
REQ-032 After a last beat leaves stage 2, accumulator, sat flag and counter clear; the next beat starts from zero, back-to-back with no bubble.
REQ-033 sum_out is valid on every output beat, not only the last.

Reset
REQ-034 reset_n low asynchronously clears valid_out, loss_out, sum_out, last_out, sat_out, len_err_out, stage-1 registers, accumulator and counter to 0, and forces IDLE.
REQ-035 Reset mid-vector discards the partial vector; no output beat is emitted for it.
REQ-036 ready_out is 1 while reset_n is low (valid_out = 0), but no beat is captured until reset_n is high at the clock edge.

Structure
REQ-037 Package tpu_loss_pkg holds loss_mode_t (LOSS_L1=0, LOSS_L2=1) and the FSM state typedef.
REQ-038 Sub-module loss_lane computes one lane's diff, abs/square and saturation; instantiated LANES times.

Verification
REQ-039 L1, LANES=4, data {5,-3,7,0}, target {2,1,7,-4}, last=1 -> loss {3,4,0,4}, sum 11, last_out=1, 2 cycles later.
REQ-040 L2, three beats all lanes diff 2, last on beat 3 -> sum_out 16, 32, 48; last_out only on beat 3.
REQ-041 L2, data 0x7FFFFFFF, target 0x80000000 -> lane loss 0xFFFFFFFF, sat_out=1 through last_out.
REQ-042 ready_in low 5 cycles mid-vector -> ready_out low, outputs held stable, no beat lost or duplicated.
REQ-043 64 beats without last_in -> beat 64 emitted with last_out=1, len_err_out=1; beat 65 sum starts from zero.
REQ-044 reset_n pulsed low after 2 beats -> all outputs 0 immediately; next vector sum excludes the discarded beats.

Source files
------------

// File: rtl/tpu_loss_pkg.sv
// Shared types for the loss accumulator: loss mode selector and vector FSM state.
package tpu_loss_pkg;

    typedef enum logic {
        LOSS_L1 = 1'b0,
        LOSS_L2 = 1'b1
    } loss_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } accum_state_t;

endpackage

// File: rtl/loss_lane.sv
// One lane of the loss datapath: widened difference, |diff| or diff^2,
// then clip to the loss width with a saturation flag.
module loss_lane
    import tpu_loss_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LOSS_W = 32
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_target,
    input  loss_mode_t        i_mode,
    output logic [LOSS_W-1:0] o_loss,
    output logic              o_sat
);

    localparam int unsigned D1_W  = DATA_W + 1;
    localparam int unsigned SQ_W  = 2 * D1_W;
    // Raw result is always wider than the loss so the overflow slice is never empty.
    localparam int unsigned RAW_W = (SQ_W > LOSS_W) ? SQ_W : LOSS_W + 1;

    logic [D1_W-1:0]  w_diff;
    logic [D1_W-1:0]  w_mag;
    logic [SQ_W-1:0]  w_sq;
    logic [RAW_W-1:0] w_raw;

    // Signed difference at DATA_W+1 bits, magnitude, square and clipped result.
    always_comb begin
        w_diff = {i_data[DATA_W-1], i_data} - {i_target[DATA_W-1], i_target};
        w_mag  = w_diff[DATA_W] ? (D1_W'(0) - w_diff) : w_diff;
        w_sq   = SQ_W'(w_mag) * SQ_W'(w_mag);
        w_raw  = (i_mode == LOSS_L2) ? RAW_W'(w_sq) : RAW_W'(w_mag);
        o_sat  = |w_raw[RAW_W-1:LOSS_W];
        o_loss = o_sat ? '1 : w_raw[LOSS_W-1:0];
    end

endmodule

// File: rtl/loss_accum.sv
// Streaming per-lane L1/L2 loss with a running per-vector sum.
// Two-stage pipeline gated by a single enable; vectors are delimited by
// last_in or forcibly closed after MAX_BEATS beats.
module loss_accum
    import tpu_loss_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LOSS_W    = 32,
    parameter int unsigned ACC_W     = 48,
    parameter int unsigned MAX_BEATS = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic [LANES*DATA_W-1:0] target_in,
    input  logic                    last_in,
    input  loss_mode_t              mode_in,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [LANES*LOSS_W-1:0] loss_out,
    output logic [ACC_W-1:0]        sum_out,
    output logic                    last_out,
    output logic                    sat_out,
    output logic                    len_err_out
);

    localparam int unsigned LSUM_W = LOSS_W + $clog2(LANES);
    localparam int unsigned SUM_W  = ((ACC_W > LSUM_W) ? ACC_W : LSUM_W) + 1;
    localparam int unsigned CNT_W  = $clog2(MAX_BEATS + 1);

    // Pipeline control
    logic w_en;
    logic w_accept;
    logic w_forced;
    logic w_last_eff;

    // Vector FSM
    accum_state_t r_state;
    accum_state_t w_state_nxt;
    loss_mode_t   r_mode;
    loss_mode_t   w_mode;
    logic [CNT_W-1:0] r_cnt;

    // Lane datapath
    logic [LANES*LOSS_W-1:0] w_loss_flat;
    logic [LANES-1:0]        w_lane_sat;
    logic [LSUM_W-1:0]       w_lsum;

    // Stage 1
    logic                    r_s1_valid;
    logic [LANES*LOSS_W-1:0] r_s1_loss;
    logic [LSUM_W-1:0]       r_s1_lsum;
    logic                    r_s1_sat;
    logic                    r_s1_last;
    logic                    r_s1_len_err;

    // Stage 2 and accumulator
    logic                    r_valid_out;
    logic [LANES*LOSS_W-1:0] r_loss_out;
    logic [ACC_W-1:0]        r_sum_out;
    logic                    r_last_out;
    logic                    r_sat_out;
    logic                    r_len_err_out;
    logic [ACC_W-1:0]        r_acc;
    logic                    r_sat_acc;
    logic [SUM_W-1:0]        w_acc_sum;
    logic                    w_acc_ovf;
    logic [ACC_W-1:0]        w_sum;
    logic                    w_sat;

    assign w_en       = !r_valid_out || ready_in;
    assign ready_out  = w_en;
    assign w_accept   = valid_in && w_en;
    assign w_forced   = (r_cnt == CNT_W'(MAX_BEATS - 1)) && !last_in;
    assign w_last_eff = last_in || w_forced;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a vector opens on a non-last beat and closes on its last beat.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = w_last_eff ? ST_IDLE : ST_ACCUM;
        end
    end

    // FSM output: the first beat of a vector uses mode_in, later beats the latched mode.
    always_comb begin
        w_mode = (r_state == ST_IDLE) ? mode_in : r_mode;
    end

    // Latch the vector mode on its first accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= LOSS_L1;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            r_mode <= mode_in;
        end
    end

    // Count accepted beats within the current vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last_eff ? '0 : r_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        loss_lane #(
            .DATA_W (DATA_W),
            .LOSS_W (LOSS_W)
        ) u_lane (
            .i_data   (data_in[g*DATA_W +: DATA_W]),
            .i_target (target_in[g*DATA_W +: DATA_W]),
            .i_mode   (w_mode),
            .o_loss   (w_loss_flat[g*LOSS_W +: LOSS_W]),
            .o_sat    (w_lane_sat[g])
        );
    end

    // Sum of all lane losses, wide enough never to overflow.
    always_comb begin
        w_lsum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_lsum = w_lsum + LSUM_W'(w_loss_flat[i*LOSS_W +: LOSS_W]);
        end
    end

    // Stage 1: register lane losses, lane sum and beat flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_loss    <= '0;
            r_s1_lsum    <= '0;
            r_s1_sat     <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_len_err <= 1'b0;
        end else if (w_en) begin
            r_s1_valid   <= w_accept;
            r_s1_loss    <= w_loss_flat;
            r_s1_lsum    <= w_lsum;
            r_s1_sat     <= |w_lane_sat;
            r_s1_last    <= w_last_eff;
            r_s1_len_err <= w_forced;
        end
    end

    // Saturating accumulate of the stage-1 lane sum onto the running vector total.
    always_comb begin
        w_acc_sum = SUM_W'(r_acc) + SUM_W'(r_s1_lsum);
        w_acc_ovf = |w_acc_sum[SUM_W-1:ACC_W];
        w_sum     = w_acc_ovf ? '1 : w_acc_sum[ACC_W-1:0];
        w_sat     = r_sat_acc || r_s1_sat || w_acc_ovf;
    end

    // Stage 2: register the output beat; the running total restarts after a last beat
    // so the next vector follows back-to-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid_out   <= 1'b0;
            r_loss_out    <= '0;
            r_sum_out     <= '0;
            r_last_out    <= 1'b0;
            r_sat_out     <= 1'b0;
            r_len_err_out <= 1'b0;
            r_acc         <= '0;
            r_sat_acc     <= 1'b0;
        end else if (w_en) begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) begin
                r_loss_out    <= r_s1_loss;
                r_sum_out     <= w_sum;
                r_last_out    <= r_s1_last;
                r_sat_out     <= w_sat;
                r_len_err_out <= r_s1_len_err;
                r_acc         <= r_s1_last ? '0 : w_sum;
                r_sat_acc     <= r_s1_last ? 1'b0 : w_sat;
            end
        end
    end

    assign valid_out   = r_valid_out;
    assign loss_out    = r_loss_out;
    assign sum_out     = r_sum_out;
    assign last_out    = r_last_out;
    assign sat_out     = r_sat_out;
    assign len_err_out = r_len_err_out;

endmodule

// File: tb/tb_loss_accum.sv
// Directed self-checking bench for loss_accum with hand-computed expectations.
module tb_loss_accum;
    import tpu_loss_pkg::*;

    localparam int unsigned LANES     = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LOSS_W    = 32;
    localparam int unsigned ACC_W     = 48;
    localparam int unsigned MAX_BEATS = 64;

    logic                    clk;
    logic                    reset_n;
    logic                    valid_in;
    logic                    ready_out;
    logic [LANES*DATA_W-1:0] data_in;
    logic [LANES*DATA_W-1:0] target_in;
    logic                    last_in;
    loss_mode_t              mode_in;
    logic                    valid_out;
    logic                    ready_in;
    logic [LANES*LOSS_W-1:0] loss_out;
    logic [ACC_W-1:0]        sum_out;
    logic                    last_out;
    logic                    sat_out;
    logic                    len_err_out;

    int n_checks = 0;
    int n_fail   = 0;

    loss_accum #(
        .LANES     (LANES),
        .DATA_W    (DATA_W),
        .LOSS_W    (LOSS_W),
        .ACC_W     (ACC_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_in     (data_in),
        .target_in   (target_in),
        .last_in     (last_in),
        .mode_in     (mode_in),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .loss_out    (loss_out),
        .sum_out     (sum_out),
        .last_out    (last_out),
        .sat_out     (sat_out),
        .len_err_out (len_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [127:0] e_loss, input logic [63:0] e_sum,
                           input logic e_last, input logic e_sat, input logic e_len);
        chk({tag, ".valid"},   128'(valid_out),   128'(1'b1));
        chk({tag, ".loss"},    128'(loss_out),    e_loss);
        chk({tag, ".sum"},     128'(sum_out),     128'(e_sum));
        chk({tag, ".last"},    128'(last_out),    128'(e_last));
        chk({tag, ".sat"},     128'(sat_out),     128'(e_sat));
        chk({tag, ".len_err"}, 128'(len_err_out), 128'(e_len));
    endtask

    task automatic drive(input logic v, input logic [127:0] d, input logic [127:0] t,
                         input logic l, input loss_mode_t m);
        valid_in  = v;
        data_in   = d;
        target_in = t;
        last_in   = l;
        mode_in   = m;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, LOSS_L1);
    endtask

    initial begin
        reset_n  = 1'b0;
        ready_in = 1'b1;
        idle();

        // Reset: outputs clear, ready_out high, beats offered during reset are not captured.
        repeat (2) @(negedge clk);
        chk("rst.valid", 128'(valid_out), 128'(0));
        chk("rst.sum", 128'(sum_out), 128'(0));
        chk("rst.ready", 128'(ready_out), 128'(1));
        drive(1'b1, pack4(9, 9, 9, 9), '0, 1'b1, LOSS_L1);
        repeat (2) @(negedge clk);
        chk("rst.ready_hold", 128'(ready_out), 128'(1));
        idle();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.no_capture", 128'(valid_out), 128'(0));
        end

        // L1 single-beat vector, latency 2.
        drive(1'b1, pack4(5, -3, 7, 0), pack4(2, 1, 7, -4), 1'b1, LOSS_L1);
        @(negedge clk);
        idle();
        chk("l1.lat1", 128'(valid_out), 128'(0));
        @(negedge clk);
        chk_out("l1", pack4(3, 4, 0, 4), 64'd11, 1'b1, 1'b0, 1'b0);

        // L2 three-beat vector, diff 2 on every lane; mode_in on later beats is ignored.
        @(negedge clk);
        drive(1'b1, pack4(1, -1, 3, 0), pack4(-1, -3, 1, -2), 1'b0, LOSS_L2);
        @(negedge clk);
        drive(1'b1, pack4(1, -1, 3, 0), pack4(-1, -3, 1, -2), 1'b0, LOSS_L1);
        @(negedge clk);
        chk_out("l2.b1", pack4(4, 4, 4, 4), 64'd16, 1'b0, 1'b0, 1'b0);
        drive(1'b1, pack4(1, -1, 3, 0), pack4(-1, -3, 1, -2), 1'b1, LOSS_L1);
        @(negedge clk);
        chk_out("l2.b2", pack4(4, 4, 4, 4), 64'd32, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk_out("l2.b3", pack4(4, 4, 4, 4), 64'd48, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("l2.drain", 128'(valid_out), 128'(0));

        // Lane saturation, sticky through last, cleared for the next vector.
        drive(1'b1, pack4(32'h7FFFFFFF, 0, 0, 0), pack4(32'h80000000, 0, 0, 0), 1'b0, LOSS_L2);
        @(negedge clk);
        drive(1'b1, pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 1'b1, LOSS_L2);
        @(negedge clk);
        chk_out("sat.b1", pack4(32'hFFFFFFFF, 0, 0, 0), 64'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        drive(1'b1, pack4(1, 0, 0, 0), pack4(0, 0, 0, 0), 1'b1, LOSS_L1);
        @(negedge clk);
        chk_out("sat.b2", pack4(0, 0, 0, 0), 64'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk_out("sat.clear", pack4(1, 0, 0, 0), 64'd1, 1'b1, 1'b0, 1'b0);

        // Backpressure: ready_in low for 5 cycles mid-vector.
        @(negedge clk);
        drive(1'b1, pack4(1, 0, 0, 0), '0, 1'b0, LOSS_L1);
        @(negedge clk);
        drive(1'b1, pack4(2, 0, 0, 0), '0, 1'b0, LOSS_L1);
        @(negedge clk);
        chk_out("bp.b1", pack4(1, 0, 0, 0), 64'd1, 1'b0, 1'b0, 1'b0);
        ready_in = 1'b0;
        drive(1'b1, pack4(3, 0, 0, 0), '0, 1'b0, LOSS_L1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.ready_out", 128'(ready_out), 128'(0));
            chk_out("bp.hold", pack4(1, 0, 0, 0), 64'd1, 1'b0, 1'b0, 1'b0);
        end
        ready_in = 1'b1;
        @(negedge clk);
        chk_out("bp.b2", pack4(2, 0, 0, 0), 64'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, pack4(4, 0, 0, 0), '0, 1'b1, LOSS_L1);
        @(negedge clk);
        chk_out("bp.b3", pack4(3, 0, 0, 0), 64'd6, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk_out("bp.b4", pack4(4, 0, 0, 0), 64'd10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp.drain", 128'(valid_out), 128'(0));

        // 65 beats without last_in: beat 64 forced last with len_err, beat 65 restarts.
        for (int i = 1; i <= MAX_BEATS + 3; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                int j;
                j = i - 2;
                chk_out($sformatf("len.b%0d", j), pack4(1, 0, 0, 0),
                        64'((j <= MAX_BEATS) ? j : j - MAX_BEATS),
                        (j == MAX_BEATS), 1'b0, (j == MAX_BEATS));
            end
            if (i <= MAX_BEATS + 1) begin
                drive(1'b1, pack4(1, 0, 0, 0), '0, 1'b0, LOSS_L1);
            end else begin
                idle();
            end
        end

        // Reset mid-vector discards the partial vector and returns to IDLE.
        @(negedge clk);
        drive(1'b1, pack4(5, 0, 0, 0), '0, 1'b0, LOSS_L1);
        @(negedge clk);
        drive(1'b1, pack4(5, 0, 0, 0), '0, 1'b0, LOSS_L1);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("mid.pre_valid", 128'(valid_out), 128'(1));
        reset_n = 1'b0;
        #1;
        chk("mid.valid", 128'(valid_out), 128'(0));
        chk("mid.loss", 128'(loss_out), 128'(0));
        chk("mid.sum", 128'(sum_out), 128'(0));
        chk("mid.last", 128'(last_out), 128'(0));
        chk("mid.sat", 128'(sat_out), 128'(0));
        chk("mid.len_err", 128'(len_err_out), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid.after", 128'(valid_out), 128'(0));
        drive(1'b1, pack4(3, 0, 0, 0), '0, 1'b1, LOSS_L2);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk_out("mid.next", pack4(9, 0, 0, 0), 64'd9, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
